// File: rtl/param_memory_controller_if.sv
// CPU-side and region-side signals of param_memory_controller.
// master = CPU plus memory instances, slave = the controller.
interface param_memory_controller_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int REGION_BITS = 5,
  parameter int NUM_REGIONS = 3
);
  logic                              req;
  logic                              we;
  logic [ADDR_WIDTH-1:0]             address;
  logic [DATA_WIDTH-1:0]             data_in;
  logic [DATA_WIDTH-1:0]             data_out;
  logic                              ready;
  logic                              error;
  logic                              busy;
  logic [NUM_REGIONS-1:0]            region_sel;
  logic                              region_we;
  logic [REGION_BITS-1:0]            region_addr;
  logic [DATA_WIDTH-1:0]             region_wdata;
  logic [NUM_REGIONS*DATA_WIDTH-1:0] region_rdata;

  modport master (
    output req, we, address, data_in, region_rdata,
    input  data_out, ready, error, busy, region_sel, region_we, region_addr, region_wdata
  );

  modport slave (
    input  req, we, address, data_in, region_rdata,
    output data_out, ready, error, busy, region_sel, region_we, region_addr, region_wdata
  );
endinterface

// File: rtl/param_memory_controller.sv
// Decodes a word address onto NUM_REGIONS power-of-two regions. Each access
// has programmable wait states, a registered read-data path and a bus error.
module param_memory_controller #(
  parameter int                       DATA_WIDTH  = 32,
  parameter int                       ADDR_WIDTH  = 16,
  parameter int                       REGION_BITS = 5,
  parameter int                       NUM_REGIONS = 3,
  parameter logic [4*NUM_REGIONS-1:0] WAIT_STATES = 12'h210
) (
  input  logic clock,
  input  logic reset,
  param_memory_controller_if.slave bus
);

  localparam int IW = ADDR_WIDTH - REGION_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic                    busy_q, busy_d;
  logic [NUM_REGIONS-1:0]  sel_q, sel_d;
  logic                    rwe_q, rwe_d;
  logic [REGION_BITS-1:0]  raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]   rwdata_q, rwdata_d;

  logic [IW-1:0]           dec_idx;
  logic                    dec_mapped;
  logic [3:0]              dec_w;
  logic [NUM_REGIONS-1:0]  dec_sel;
  logic [DATA_WIDTH-1:0]   rd_slice;

  // Decode of the incoming address, plus the read mux driven by the latched index.
  always_comb begin
    dec_idx    = bus.address[ADDR_WIDTH-1:REGION_BITS];
    dec_mapped = 1'b0;
    dec_w      = '0;
    dec_sel    = '0;
    rd_slice   = '0;
    for (int unsigned k = 0; k < NUM_REGIONS; k++) begin
      if (dec_idx == IW'(k)) begin
        dec_mapped = 1'b1;
        dec_w      = WAIT_STATES[4*k +: 4];
        dec_sel[k] = 1'b1;
      end
      if (idx_q == IW'(k)) begin
        rd_slice = bus.region_rdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    error_d    = 1'b0;
    busy_d     = busy_q;
    sel_d      = sel_q;
    rwe_d      = 1'b0;
    raddr_d    = raddr_q;
    rwdata_d   = rwdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d   = bus.we;
          busy_d = 1'b1;
          if (dec_mapped) begin
            state_d  = ACCESS;
            idx_d    = dec_idx;
            cnt_d    = dec_w;
            sel_d    = dec_sel;
            raddr_d  = bus.address[REGION_BITS-1:0];
            rwdata_d = bus.data_in;
            // Strobe is registered, so it is raised one cycle ahead of the last ACCESS cycle.
            rwe_d    = bus.we && (dec_w == 4'd0);
          end else begin
            state_d = DONE;
            ready_d = 1'b1;
            error_d = 1'b1;
            if (!bus.we) begin
              data_out_d = '0;
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          sel_d   = '0;
          ready_d = 1'b1;
          if (!we_q) begin
            data_out_d = rd_slice;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          rwe_d = we_q && (cnt_q == 4'd1);
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      sel_q      <= '0;
      rwe_q      <= 1'b0;
      raddr_q    <= '0;
      rwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      sel_q      <= sel_d;
      rwe_q      <= rwe_d;
      raddr_q    <= raddr_d;
      rwdata_q   <= rwdata_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.ready        = ready_q;
  assign bus.error        = error_q;
  assign bus.busy         = busy_q;
  assign bus.region_sel   = sel_q;
  assign bus.region_we    = rwe_q;
  assign bus.region_addr  = raddr_q;
  assign bus.region_wdata = rwdata_q;

endmodule
